sc_xnor_serial_compare: RTL and testbench



---
 rtl/sc_xnor_cmp_pkg.sv | 20 ++
 rtl/sc_xnor_serial_compare_gate.sv | 12 +
 rtl/sc_xnor_serial_compare.sv | 110 +++++++++++
 tb/tb_sc_xnor_serial_compare.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_xnor_cmp_pkg.sv
// Shared types and helpers for the bit-serial XNOR equality comparator.
// State encoding and index-width function.
package sc_xnor_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sc_xnor_serial_compare_gate.sv
// Single-bit XNOR gate cell, the only datapath of the serial comparator.
// Purely combinational.
module CC_GateXNOR (
  input  logic CC_GateXNOR_a_In,
  input  logic CC_GateXNOR_b_In,
  output logic CC_GateXNOR_z_Out
);

  assign CC_GateXNOR_z_Out =
    ~(CC_GateXNOR_a_In ^ CC_GateXNOR_b_In);

endmodule

// File: rtl/sc_xnor_serial_compare.sv
// Bit-serial equality compare, LSB first, through one shared XNOR cell.
// Registered verdict with a one-cycle done pulse.
module sc_xnor_serial_compare
  import sc_xnor_cmp_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                          SC_XnorSerialCompare_CLOCK_50,
  input  logic                          SC_XnorSerialCompare_RESET_InLow,
  input  logic                          SC_XnorSerialCompare_start_In,
  input  logic [DATAWIDTH-1:0]          SC_XnorSerialCompare_a_In,
  input  logic [DATAWIDTH-1:0]          SC_XnorSerialCompare_b_In,
  output logic                          SC_XnorSerialCompare_busy_Out,
  output logic                          SC_XnorSerialCompare_done_Out,
  output logic                          SC_XnorSerialCompare_equal_Out,
  output logic [clog2(DATAWIDTH)-1:0]   SC_XnorSerialCompare_mismatchIdx_Out
);

  localparam int IW = clog2(DATAWIDTH);
  localparam logic [IW-1:0] LAST = IW'(DATAWIDTH - 1);

  logic clk;
  logic rst_n;
  logic start;

  assign clk   = SC_XnorSerialCompare_CLOCK_50;
  assign rst_n = SC_XnorSerialCompare_RESET_InLow;
  assign start = SC_XnorSerialCompare_start_In;

  state_t                state;
  state_t                state_n;
  logic [DATAWIDTH-1:0]  sh_a;
  logic [DATAWIDTH-1:0]  sh_b;
  logic [IW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic                  flag;
  logic                  z;

  CC_GateXNOR u_gate (
    .CC_GateXNOR_a_In  (sh_a[0]),
    .CC_GateXNOR_b_In  (sh_b[0]),
    .CC_GateXNOR_z_Out (z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = SHIFT;
      SHIFT: begin
        if ((EARLY_EXIT != 0) && !z) state_n = DONE;
        else if (cnt == LAST)        state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      idx   <= '0;
      flag  <= 1'b0;
      SC_XnorSerialCompare_busy_Out        <= 1'b0;
      SC_XnorSerialCompare_done_Out        <= 1'b0;
      SC_XnorSerialCompare_equal_Out       <= 1'b0;
      SC_XnorSerialCompare_mismatchIdx_Out <= '0;
    end else begin
      SC_XnorSerialCompare_busy_Out <= (state_n == SHIFT);
      SC_XnorSerialCompare_done_Out <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            sh_a <= SC_XnorSerialCompare_a_In;
            sh_b <= SC_XnorSerialCompare_b_In;
            cnt  <= '0;
            idx  <= '0;
            flag <= 1'b0;
            SC_XnorSerialCompare_equal_Out <= 1'b0;
          end
        end
        SHIFT: begin
          // only the first mismatch is recorded
          if (!z && !flag) begin
            flag <= 1'b1;
            idx  <= cnt;
          end
          if (state_n == SHIFT) begin
            sh_a <= sh_a >> 1;
            sh_b <= sh_b >> 1;
            cnt  <= cnt + IW'(1);
          end
        end
        DONE: begin
          SC_XnorSerialCompare_equal_Out       <= ~flag;
          SC_XnorSerialCompare_mismatchIdx_Out <= flag ? idx : '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sc_xnor_serial_compare.sv
// Directed bench for sc_xnor_serial_compare, W=8.
// Two instances: dut0 full scan, dut1 early exit, sharing all inputs.
module tb_sc_xnor_serial_compare;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;

  logic       busy0, done0, eq0;
  logic [2:0] idx0;
  logic       busy1, done1, eq1;
  logic [2:0] idx1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sc_xnor_serial_compare #(.DATAWIDTH(8), .EARLY_EXIT(0)) dut0 (
    .SC_XnorSerialCompare_CLOCK_50        (clk),
    .SC_XnorSerialCompare_RESET_InLow     (rst_n),
    .SC_XnorSerialCompare_start_In        (start),
    .SC_XnorSerialCompare_a_In            (a),
    .SC_XnorSerialCompare_b_In            (b),
    .SC_XnorSerialCompare_busy_Out        (busy0),
    .SC_XnorSerialCompare_done_Out        (done0),
    .SC_XnorSerialCompare_equal_Out       (eq0),
    .SC_XnorSerialCompare_mismatchIdx_Out (idx0)
  );

  sc_xnor_serial_compare #(.DATAWIDTH(8), .EARLY_EXIT(1)) dut1 (
    .SC_XnorSerialCompare_CLOCK_50        (clk),
    .SC_XnorSerialCompare_RESET_InLow     (rst_n),
    .SC_XnorSerialCompare_start_In        (start),
    .SC_XnorSerialCompare_a_In            (a),
    .SC_XnorSerialCompare_b_In            (b),
    .SC_XnorSerialCompare_busy_Out        (busy1),
    .SC_XnorSerialCompare_done_Out        (done1),
    .SC_XnorSerialCompare_equal_Out       (eq1),
    .SC_XnorSerialCompare_mismatchIdx_Out (idx1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One start pulse, then 14 idle cycles; reports first done cycle,
  // done count and busy cycle count for each instance (-1 = no done).
  task automatic run_cmp(
    input  logic [7:0] va,
    input  logic [7:0] vb,
    output int d0, output int d1,
    output int nd0, output int nd1,
    output int nb0, output int nb1
  );
    d0 = -1; d1 = -1; nd0 = 0; nd1 = 0; nb0 = 0; nb1 = 0;
    a = va; b = vb; start = 1'b1;
    tick();
    start = 1'b0;
    a = ~va; b = vb ^ 8'h5A;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) tick();
      if (busy0) nb0++;
      if (busy1) nb1++;
      if (done0) begin nd0++; if (d0 < 0) d0 = c; end
      if (done1) begin nd1++; if (d1 < 0) d1 = c; end
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_checks++;
      if ({busy0, done0, eq0, idx0, busy1, done1, eq1, idx1} !== 12'h0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got=%b%b%b%0d %b%b%b%0d want all 0",
                 c, busy0, done0, eq0, idx0, busy1, done1, eq1, idx1);
      end
    end
  endtask

  task automatic test_equal();
    int d0, d1, nd0, nd1, nb0, nb1;
    run_cmp(8'hA5, 8'hA5, d0, d1, nd0, nd1, nb0, nb1);
    n_checks++;
    if (d1 !== 9 || nd1 !== 1) begin
      n_fail++;
      $display("FAIL eq_ee1_done got=%0d n=%0d want=9 n=1", d1, nd1);
    end
    n_checks++;
    if (nb1 !== 8) begin
      n_fail++;
      $display("FAIL eq_ee1_busy got=%0d want=8", nb1);
    end
    n_checks++;
    if (eq1 !== 1'b1 || idx1 !== 3'd0) begin
      n_fail++;
      $display("FAIL eq_ee1_verdict got=%b/%0d want=1/0", eq1, idx1);
    end
    n_checks++;
    if (d0 !== 9 || nb0 !== 8 || eq0 !== 1'b1 || idx0 !== 3'd0) begin
      n_fail++;
      $display("FAIL eq_ee0 got d=%0d b=%0d e=%b i=%0d want 9/8/1/0",
               d0, nb0, eq0, idx0);
    end
  endtask

  task automatic test_mismatch_bit2();
    int d0, d1, nd0, nd1, nb0, nb1;
    run_cmp(8'hA5, 8'hA1, d0, d1, nd0, nd1, nb0, nb1);
    n_checks++;
    if (d1 !== 4 || nd1 !== 1 || nb1 !== 3) begin
      n_fail++;
      $display("FAIL mm2_ee1_timing got d=%0d n=%0d b=%0d want 4/1/3",
               d1, nd1, nb1);
    end
    n_checks++;
    if (eq1 !== 1'b0 || idx1 !== 3'd2) begin
      n_fail++;
      $display("FAIL mm2_ee1_verdict got=%b/%0d want=0/2", eq1, idx1);
    end
    n_checks++;
    if (d0 !== 9 || nb0 !== 8) begin
      n_fail++;
      $display("FAIL mm2_ee0_timing got d=%0d b=%0d want 9/8", d0, nb0);
    end
    n_checks++;
    if (eq0 !== 1'b0 || idx0 !== 3'd2) begin
      n_fail++;
      $display("FAIL mm2_ee0_verdict got=%b/%0d want=0/2", eq0, idx0);
    end
  endtask

  task automatic test_mismatch_msb();
    int d0, d1, nd0, nd1, nb0, nb1;
    run_cmp(8'h80, 8'h00, d0, d1, nd0, nd1, nb0, nb1);
    n_checks++;
    if (d0 !== 9 || eq0 !== 1'b0 || idx0 !== 3'd7) begin
      n_fail++;
      $display("FAIL msb_ee0 got d=%0d e=%b i=%0d want 9/0/7",
               d0, eq0, idx0);
    end
    n_checks++;
    if (d1 !== 9 || eq1 !== 1'b0 || idx1 !== 3'd7) begin
      n_fail++;
      $display("FAIL msb_ee1 got d=%0d e=%b i=%0d want 9/0/7",
               d1, eq1, idx1);
    end
  endtask

  task automatic test_back_to_back();
    int p0[$];
    int p1[$];
    int bad_eq;
    bad_eq = 0;
    a = 8'h3C; b = 8'h3C; start = 1'b1;
    tick();
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (done0) begin p0.push_back(c); if (eq0 !== 1'b1) bad_eq++; end
      if (done1) begin p1.push_back(c); if (eq1 !== 1'b1) bad_eq++; end
    end
    start = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (p0.size() !== 3 || p0[0] !== 9 || p0[1] !== 19 || p0[2] !== 29) begin
      n_fail++;
      $display("FAIL b2b_ee0 got n=%0d want done at 9,19,29", p0.size());
    end
    n_checks++;
    if (p1.size() !== 3 || p1[0] !== 9 || p1[1] !== 19 || p1[2] !== 29) begin
      n_fail++;
      $display("FAIL b2b_ee1 got n=%0d want done at 9,19,29", p1.size());
    end
    n_checks++;
    if (bad_eq !== 0 || eq0 !== 1'b1 || eq1 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_equal got bad=%0d e0=%b e1=%b want 0/1/1",
               bad_eq, eq0, eq1);
    end
  endtask

  task automatic test_reset_abort();
    int d0, d1, nd0, nd1, nb0, nb1;
    int seen;
    seen = 0;
    a = 8'hFF; b = 8'h00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_busy_before got=%b want=1", busy0);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy0, done0, eq0, idx0, busy1, done1, eq1, idx1} !== 12'h0) begin
      n_fail++;
      $display("FAIL abort_async got=%b%b%b%0d %b%b%b%0d want all 0",
               busy0, done0, eq0, idx0, busy1, done1, eq1, idx1);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done0 || done1 || busy0 || busy1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done got=%0d active cycles want=0", seen);
    end
    run_cmp(8'h12, 8'h12, d0, d1, nd0, nd1, nb0, nb1);
    n_checks++;
    if (d0 !== 9 || eq0 !== 1'b1 || idx0 !== 3'd0 || nd0 !== 1) begin
      n_fail++;
      $display("FAIL abort_after got d=%0d e=%b i=%0d want 9/1/0",
               d0, eq0, idx0);
    end
  endtask

  initial begin
    test_reset();
    test_equal();
    test_mismatch_bit2();
    test_mismatch_msb();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
